// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared processing-element types, widths and arithmetic helpers
package pe_pkg;

    localparam int PAYLOAD_WIDTH = 32;
    localparam int TYPE_WIDTH    = 3;

    localparam logic [TYPE_WIDTH-1:0] TYPE_DATA       = 3'b000;
    localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_INB   = 3'b001;
    localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_W     = 3'b010;
    localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_AFLUT = 3'b100;
    localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_AFLB  = 3'b101;
    localparam logic [TYPE_WIDTH-1:0] TYPE_CONF_AFUB  = 3'b110;

    // Integer square root, used only at elaboration time.
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        for (int i = 0; i <= n; i++) begin
            if (i * i <= n) r = i;
        end
        return r;
    endfunction

    function automatic int source_width(input int network_size);
        return $clog2(network_size);
    endfunction

    function automatic int seq_width(input int network_size);
        return $clog2(isqrt(network_size) * 2);
    endfunction

    // Signed add clamped to the most positive/negative value on overflow.
    function automatic logic [PAYLOAD_WIDTH-1:0] sat_add(
        input logic [PAYLOAD_WIDTH-1:0] a,
        input logic [PAYLOAD_WIDTH-1:0] b
    );
        logic [PAYLOAD_WIDTH-1:0] s;
        s = a + b;
        if ((a[PAYLOAD_WIDTH-1] == b[PAYLOAD_WIDTH-1]) && (s[PAYLOAD_WIDTH-1] != a[PAYLOAD_WIDTH-1]))
            s = a[PAYLOAD_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s;
    endfunction

endpackage

// File: rtl/pe_accumulator_if.sv
// rtl/pe_accumulator_if.sv - multiplier-to-accumulator and accumulator-to-activation streams
interface pe_accumulator_if
    import pe_pkg::*;
#(
    parameter int NETWORK_SIZE = 256
);
    localparam int SOURCE_WIDTH = source_width(NETWORK_SIZE);
    localparam int SEQ_WIDTH    = seq_width(NETWORK_SIZE);

    logic                     MUL_ACC_valid;
    logic [TYPE_WIDTH-1:0]    MUL_ACC_type;
    logic [SEQ_WIDTH-1:0]     MUL_ACC_seqNum;
    logic [SOURCE_WIDTH-1:0]  MUL_ACC_inputNum;
    logic [PAYLOAD_WIDTH-1:0] MUL_ACC_data;
    logic                     MUL_ACC_halt;

    logic                     ACC_AF_valid;
    logic [TYPE_WIDTH-1:0]    ACC_AF_type;
    logic [SEQ_WIDTH-1:0]     ACC_AF_seqNum;
    logic [PAYLOAD_WIDTH-1:0] ACC_AF_data;
    logic                     ACC_AF_halt;

    modport master (
        output MUL_ACC_valid, MUL_ACC_type, MUL_ACC_seqNum, MUL_ACC_inputNum, MUL_ACC_data,
        input  MUL_ACC_halt,
        input  ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data,
        output ACC_AF_halt
    );

    modport slave (
        input  MUL_ACC_valid, MUL_ACC_type, MUL_ACC_seqNum, MUL_ACC_inputNum, MUL_ACC_data,
        output MUL_ACC_halt,
        output ACC_AF_valid, ACC_AF_type, ACC_AF_seqNum, ACC_AF_data,
        input  ACC_AF_halt
    );

endinterface

// File: rtl/pe_accumulator_bank.sv
// rtl/pe_accumulator_bank.sv - per-sequence sum/count register file (acc_bank)
module acc_bank
    import pe_pkg::*;
#(
    parameter int AW = 5,
    parameter int CW = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            rd_addr,
    output logic [PAYLOAD_WIDTH-1:0] rd_sum,
    output logic [CW-1:0]            rd_count,
    input  logic                     we,
    input  logic [AW-1:0]            wr_addr,
    input  logic [PAYLOAD_WIDTH-1:0] wr_sum,
    input  logic [CW-1:0]            wr_count,
    input  logic                     clr_all
);
    localparam int DEPTH = 1 << AW;

    logic [PAYLOAD_WIDTH-1:0] sum_q   [DEPTH];
    logic [CW-1:0]            count_q [DEPTH];

    assign rd_sum   = sum_q[rd_addr];
    assign rd_count = count_q[rd_addr];

    // Entry storage: clear-all wins over a single-entry write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sum_q[i]   <= '0;
                count_q[i] <= '0;
            end
        end else if (clr_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                sum_q[i]   <= '0;
                count_q[i] <= '0;
            end
        end else if (we) begin
            sum_q[wr_addr]   <= wr_sum;
            count_q[wr_addr] <= wr_count;
        end
    end

endmodule

// File: rtl/pe_accumulator.sv
// rtl/pe_accumulator.sv - sums signed products per sequence; optional ACC_SATURATE_EN clamps on overflow
module pe_accumulator
    import pe_pkg::*;
#(
    parameter int NETWORK_SIZE = 256
) (
    input logic       clk,
    input logic       rst,
    pe_accumulator_if.slave bus
);
    localparam int SOURCE_WIDTH = source_width(NETWORK_SIZE);
    localparam int SEQ_WIDTH    = seq_width(NETWORK_SIZE);
    localparam int CW           = SOURCE_WIDTH + 1;

    logic                     accept;
    logic [CW-1:0]            inb_q;
    logic [PAYLOAD_WIDTH-1:0] rd_sum;
    logic [CW-1:0]            rd_count;
    logic [PAYLOAD_WIDTH-1:0] new_sum;
    logic [CW-1:0]            new_count;
    logic                     is_data;
    logic                     complete;
    logic                     passthru;
    logic                     load;
    logic                     we;
    logic                     clr_all;
    logic [PAYLOAD_WIDTH-1:0] wr_sum;
    logic [CW-1:0]            wr_count;
    logic                     unused_input_num;

    // The source index is informational only; duplicates are counted again.
    assign unused_input_num = ^bus.MUL_ACC_inputNum;

    assign bus.MUL_ACC_halt = bus.ACC_AF_valid && bus.ACC_AF_halt;
    assign accept           = bus.MUL_ACC_valid && !bus.MUL_ACC_halt;

    acc_bank #(.AW(SEQ_WIDTH), .CW(CW)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (bus.MUL_ACC_seqNum),
        .rd_sum   (rd_sum),
        .rd_count (rd_count),
        .we       (we),
        .wr_addr  (bus.MUL_ACC_seqNum),
        .wr_sum   (wr_sum),
        .wr_count (wr_count),
        .clr_all  (clr_all)
    );

    // Single-cycle read-modify-write of the addressed entry and output decision.
    always_comb begin
`ifdef ACC_SATURATE_EN
        new_sum = sat_add(rd_sum, bus.MUL_ACC_data);
`else
        new_sum = rd_sum + bus.MUL_ACC_data;
`endif
        new_count = rd_count + 1'b1;
        is_data   = (bus.MUL_ACC_type == TYPE_DATA) && (inb_q != '0);
        complete  = is_data && (new_count == inb_q);
        passthru  = (bus.MUL_ACC_type == TYPE_CONF_AFLUT) ||
                    (bus.MUL_ACC_type == TYPE_CONF_AFLB)  ||
                    (bus.MUL_ACC_type == TYPE_CONF_AFUB);
        we        = accept && is_data;
        wr_sum    = complete ? '0 : new_sum;
        wr_count  = complete ? '0 : new_count;
        clr_all   = accept && (bus.MUL_ACC_type == TYPE_CONF_INB);
        load      = accept && (complete || passthru);
    end

    // Expected-input count, reprogrammed by CONF_INB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            inb_q <= '0;
        else if (clr_all)
            inb_q <= bus.MUL_ACC_data[CW-1:0];
    end

    // Output register: loads on completion/pass-through, holds while halted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.ACC_AF_valid  <= 1'b0;
            bus.ACC_AF_type   <= '0;
            bus.ACC_AF_seqNum <= '0;
            bus.ACC_AF_data   <= '0;
        end else if (load) begin
            bus.ACC_AF_valid  <= 1'b1;
            bus.ACC_AF_type   <= bus.MUL_ACC_type;
            bus.ACC_AF_seqNum <= bus.MUL_ACC_seqNum;
            bus.ACC_AF_data   <= complete ? new_sum : bus.MUL_ACC_data;
        end else if (!bus.ACC_AF_halt) begin
            bus.ACC_AF_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_accumulator.sv
// tb/tb_pe_accumulator.sv - scoreboard bench for pe_accumulator
module tb_pe_accumulator;
    import pe_pkg::*;

    typedef struct {
        logic [2:0]  t;
        logic [4:0]  s;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t expq[$];

    pe_accumulator_if #(.NETWORK_SIZE(256)) bus ();

    pe_accumulator #(.NETWORK_SIZE(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input logic [2:0] t, input logic [4:0] s, input logic [31:0] d);
        exp_t e;
        e.t = t;
        e.s = s;
        e.d = d;
        expq.push_back(e);
    endtask

    // Drive one beat from a negedge and return at the negedge after it is accepted.
    task automatic send(input logic [2:0] t, input logic [4:0] s, input logic [31:0] d);
        int n;
        bus.MUL_ACC_valid    = 1'b1;
        bus.MUL_ACC_type     = t;
        bus.MUL_ACC_seqNum   = s;
        bus.MUL_ACC_inputNum = 8'(s);
        bus.MUL_ACC_data     = d;
        #1;
        n = 0;
        while (bus.MUL_ACC_halt && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 50) check("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.MUL_ACC_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Output consumed at the next posedge when valid and not halted.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst && bus.ACC_AF_valid && !bus.ACC_AF_halt) begin
            if (expq.size() == 0) begin
                check("unexpected_out", {bus.ACC_AF_type, bus.ACC_AF_seqNum, 24'(0)}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                check("out_type", 32'(bus.ACC_AF_type), 32'(e.t));
                check("out_seq", 32'(bus.ACC_AF_seqNum), 32'(e.s));
                check("out_data", bus.ACC_AF_data, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.MUL_ACC_valid    = 1'b0;
        bus.MUL_ACC_type     = '0;
        bus.MUL_ACC_seqNum   = '0;
        bus.MUL_ACC_inputNum = '0;
        bus.MUL_ACC_data     = '0;
        bus.ACC_AF_halt      = 1'b0;
        idle(3);
        check("rst_valid", 32'(bus.ACC_AF_valid), 32'd0);
        check("rst_type", 32'(bus.ACC_AF_type), 32'd0);
        check("rst_seq", 32'(bus.ACC_AF_seqNum), 32'd0);
        check("rst_data", bus.ACC_AF_data, 32'd0);
        check("rst_halt", 32'(bus.MUL_ACC_halt), 32'd0);
        rst = 1'b1;
        idle(2);

        // Four beats to seq 3, output one cycle after the last.
        send(TYPE_CONF_INB, 5'd0, 32'd4);
        send(TYPE_DATA, 5'd3, 32'd10);
        send(TYPE_DATA, 5'd3, -32'sd3);
        send(TYPE_DATA, 5'd3, 32'd7);
        check("t1_early_valid", 32'(bus.ACC_AF_valid), 32'd0);
        expect_out(TYPE_DATA, 5'd3, 32'd15);
        send(TYPE_DATA, 5'd3, 32'd1);
        check("t1_valid", 32'(bus.ACC_AF_valid), 32'd1);
        idle(3);

        // Interleaved sequences.
        send(TYPE_CONF_INB, 5'd0, 32'd2);
        send(TYPE_DATA, 5'd0, 32'd5);
        send(TYPE_DATA, 5'd1, 32'd100);
        expect_out(TYPE_DATA, 5'd0, 32'd11);
        send(TYPE_DATA, 5'd0, 32'd6);
        expect_out(TYPE_DATA, 5'd1, 32'd99);
        send(TYPE_DATA, 5'd1, -32'sd1);
        idle(3);

        // Backpressure: halt with empty output has no effect, then holds.
        send(TYPE_CONF_INB, 5'd0, 32'd1);
        bus.ACC_AF_halt = 1'b1;
        expect_out(TYPE_DATA, 5'd2, 32'd42);
        send(TYPE_DATA, 5'd2, 32'd42);
        check("halt_in", 32'(bus.MUL_ACC_halt), 32'd1);
        expect_out(TYPE_DATA, 5'd5, 32'd77);
        bus.MUL_ACC_valid  = 1'b1;
        bus.MUL_ACC_type   = TYPE_DATA;
        bus.MUL_ACC_seqNum = 5'd5;
        bus.MUL_ACC_data   = 32'd77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_hold_data", bus.ACC_AF_data, 32'd42);
            check("halt_hold_valid", 32'(bus.ACC_AF_valid), 32'd1);
            check("halt_hold_in", 32'(bus.MUL_ACC_halt), 32'd1);
        end
        bus.ACC_AF_halt = 1'b0;
        @(negedge clk);
        bus.MUL_ACC_valid = 1'b0;
        check("release_data", bus.ACC_AF_data, 32'd77);
        check("release_valid", 32'(bus.ACC_AF_valid), 32'd1);
        idle(3);

        // Pass-through and dropped weight config.
        expect_out(TYPE_CONF_AFUB, 5'd9, 32'h1234_5678);
        send(TYPE_CONF_AFUB, 5'd9, 32'h1234_5678);
        idle(2);
        send(TYPE_CONF_W, 5'd9, 32'd5);
        idle(3);

        // Overflow behaviour.
        send(TYPE_CONF_INB, 5'd0, 32'd2);
        send(TYPE_DATA, 5'd4, 32'h7FFF_FFF0);
`ifdef ACC_SATURATE_EN
        expect_out(TYPE_DATA, 5'd4, 32'h7FFF_FFFF);
`else
        expect_out(TYPE_DATA, 5'd4, 32'h8000_0010);
`endif
        send(TYPE_DATA, 5'd4, 32'h0000_0020);
        idle(3);

        // Partial sequence discarded by reprogramming inb.
        send(TYPE_CONF_INB, 5'd0, 32'd3);
        send(TYPE_DATA, 5'd7, 32'd100);
        send(TYPE_CONF_INB, 5'd0, 32'd3);
        send(TYPE_DATA, 5'd7, 32'd1);
        send(TYPE_DATA, 5'd7, 32'd2);
        expect_out(TYPE_DATA, 5'd7, 32'd6);
        send(TYPE_DATA, 5'd7, 32'd3);

        n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(expq.size()), 32'd0);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
